// File: rtl/jpeg_pkg.sv
// Shared JPEG front-end definitions: pixel/block geometry, packer state
// encoding and the signed DCT input sample type.
package jpeg_pkg;

  localparam int PIX_W        = 8;
  localparam int BLK_DIM      = 8;
  localparam int LEVEL_OFFSET = 128;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pk_state_e;

  typedef logic signed [PIX_W-1:0] dct_sample_t;

  // Subtracting 128 from an unsigned 8-bit value only flips the MSB.
  function automatic dct_sample_t level_shift(input logic [PIX_W-1:0] pix);
    return dct_sample_t'(pix ^ PIX_W'(LEVEL_OFFSET));
  endfunction

endpackage

// File: rtl/dct_row_packer.sv
// Level-shifts a raster pixel stream and packs each 8 samples into a
// registered row vector for the row DCT, tracking row/block position.
module dct_row_packer
  import jpeg_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  input  logic                 pix_sob,
  output logic                 pix_ready,
  output dct_sample_t          x0,
  output dct_sample_t          x1,
  output dct_sample_t          x2,
  output dct_sample_t          x3,
  output dct_sample_t          x4,
  output dct_sample_t          x5,
  output dct_sample_t          x6,
  output dct_sample_t          x7,
  output logic                 row_valid,
  output logic [2:0]           row_idx,
  output logic                 blk_first,
  output logic                 blk_last,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 err_sob,
  output logic                 drop
);

  localparam logic [2:0] LAST_IDX = 3'(BLK_DIM - 1);

  pk_state_e             state_r, state_nxt_s;
  logic [2:0]            col_r, col_nxt_s;
  logic [2:0]            row_r, row_nxt_s;
  dct_sample_t           stage_r [0:BLK_DIM-2];
  dct_sample_t           x_r     [0:BLK_DIM-1];
  dct_sample_t           sample_s;
  logic                  accept_s;
  logic                  store_s;
  logic [2:0]            store_idx_s;
  logic                  emit_s;
  logic                  blk_done_s;
  logic                  err_s;
  logic                  drop_s;
  logic                  pix_ready_r;
  logic                  row_valid_r;
  logic [2:0]            row_idx_r;
  logic                  blk_first_r;
  logic                  blk_last_r;
  logic [BLK_CNT_W-1:0]  blk_cnt_r;
  logic                  err_sob_r;
  logic                  drop_r;

  assign accept_s = pix_valid & pix_ready_r;
  assign sample_s = level_shift(pix_data);

  // Next-state and per-accept control decode.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    store_s     = 1'b0;
    store_idx_s = 3'd0;
    emit_s      = 1'b0;
    blk_done_s  = 1'b0;
    err_s       = 1'b0;
    drop_s      = 1'b0;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (pix_sob) begin
            state_nxt_s = ACTIVE;
            store_s     = 1'b1;
            col_nxt_s   = 3'd1;
            row_nxt_s   = 3'd0;
          end else begin
            drop_s = 1'b1;
          end
        end
        ACTIVE: begin
          if (pix_sob) begin
            // Restart: partial row discarded, this pixel opens a new block.
            err_s     = 1'b1;
            store_s   = 1'b1;
            col_nxt_s = 3'd1;
            row_nxt_s = 3'd0;
          end else if (col_r == LAST_IDX) begin
            emit_s    = 1'b1;
            col_nxt_s = 3'd0;
            if (row_r == LAST_IDX) begin
              blk_done_s  = 1'b1;
              row_nxt_s   = 3'd0;
              state_nxt_s = IDLE;
            end else begin
              row_nxt_s = row_r + 3'd1;
            end
          end else begin
            store_s     = 1'b1;
            store_idx_s = col_r;
            col_nxt_s   = col_r + 3'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Control state, position counters and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      col_r       <= 3'd0;
      row_r       <= 3'd0;
      pix_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      col_r       <= col_nxt_s;
      row_r       <= row_nxt_s;
      pix_ready_r <= 1'b1;
    end
  end

  // Staging register for columns 0..6 of the row in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_DIM - 1; i++) begin
        stage_r[i] <= 8'sd0;
      end
    end else begin
      for (int i = 0; i < BLK_DIM - 1; i++) begin
        if (store_s && (store_idx_s == 3'(i))) begin
          stage_r[i] <= sample_s;
        end
      end
    end
  end

  // Row output registers, block counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_DIM; i++) begin
        x_r[i] <= 8'sd0;
      end
      row_valid_r <= 1'b0;
      row_idx_r   <= 3'd0;
      blk_first_r <= 1'b0;
      blk_last_r  <= 1'b0;
      blk_cnt_r   <= '0;
      err_sob_r   <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      if (emit_s) begin
        for (int i = 0; i < BLK_DIM - 1; i++) begin
          x_r[i] <= stage_r[i];
        end
        x_r[BLK_DIM-1] <= sample_s;
        row_idx_r      <= row_r;
      end
      if (blk_done_s) begin
        blk_cnt_r <= blk_cnt_r + BLK_CNT_W'(1);
      end
      row_valid_r <= emit_s;
      blk_first_r <= emit_s & (row_r == 3'd0);
      blk_last_r  <= emit_s & (row_r == LAST_IDX);
      err_sob_r   <= err_s;
      drop_r      <= drop_s;
    end
  end

  assign pix_ready = pix_ready_r;
  assign x0        = x_r[0];
  assign x1        = x_r[1];
  assign x2        = x_r[2];
  assign x3        = x_r[3];
  assign x4        = x_r[4];
  assign x5        = x_r[5];
  assign x6        = x_r[6];
  assign x7        = x_r[7];
  assign row_valid = row_valid_r;
  assign row_idx   = row_idx_r;
  assign blk_first = blk_first_r;
  assign blk_last  = blk_last_r;
  assign blk_cnt   = blk_cnt_r;
  assign err_sob   = err_sob_r;
  assign drop      = drop_r;

endmodule

// File: tb/tb_dct_row_packer.sv
// Scoreboard bench for dct_row_packer: a reference model queues expected rows
// as pixels are driven; a negedge monitor pops and compares each row_valid.
module tb_dct_row_packer;

  typedef struct {
    logic [63:0] x;
    logic [2:0]  idx;
    logic        first;
    logic        last;
    logic [15:0] blk;
  } row_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_valid = 1'b0;
  logic [7:0]        pix_data = 8'd0;
  logic              pix_sob = 1'b0;
  logic              pix_ready;
  logic signed [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic              row_valid;
  logic [2:0]        row_idx;
  logic              blk_first, blk_last;
  logic [15:0]       blk_cnt;
  logic              err_sob, drop;

  dct_row_packer #(.BLK_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sob(pix_sob), .pix_ready(pix_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .row_valid(row_valid), .row_idx(row_idx), .blk_first(blk_first),
    .blk_last(blk_last), .blk_cnt(blk_cnt), .err_sob(err_sob), .drop(drop)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  row_t exp_q[$];
  row_t got_q[$];
  int   got_cyc[$];
  row_t mon_g, mon_e;

  bit   m_active;
  int   m_col, m_row, m_blk;
  int   m_stage[8];
  int   exp_drop, exp_err, drop_seen, err_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic sob);
    int   s;
    row_t r;
    s = int'(d) - 128;
    if (!m_active) begin
      if (sob) begin
        m_stage[0] = s; m_col = 1; m_row = 0; m_active = 1'b1;
      end else begin
        exp_drop++;
      end
    end else if (sob) begin
      exp_err++;
      m_stage[0] = s; m_col = 1; m_row = 0;
    end else begin
      m_stage[m_col] = s;
      if (m_col == 7) begin
        r.x = 64'd0;
        for (int i = 0; i < 8; i++) r.x[i*8 +: 8] = 8'(m_stage[i]);
        r.idx   = 3'(m_row);
        r.first = (m_row == 0);
        r.last  = (m_row == 7);
        if (m_row == 7) begin
          m_blk++; m_row = 0; m_active = 1'b0;
        end else begin
          m_row++;
        end
        r.blk = 16'(m_blk);
        m_col = 0;
        exp_q.push_back(r);
      end else begin
        m_col++;
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Row/pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (drop) drop_seen++;
      if (err_sob) err_seen++;
      if (row_valid) begin
        mon_g.x     = {x7, x6, x5, x4, x3, x2, x1, x0};
        mon_g.idx   = row_idx;
        mon_g.first = blk_first;
        mon_g.last  = blk_last;
        mon_g.blk   = blk_cnt;
        got_q.push_back(mon_g);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("row_x", mon_g.x, mon_e.x);
          chk("row_idx", 64'(mon_g.idx), 64'(mon_e.idx));
          chk("blk_first", 64'(mon_g.first), 64'(mon_e.first));
          chk("blk_last", 64'(mon_g.last), 64'(mon_e.last));
          chk("blk_cnt", 64'(mon_g.blk), 64'(mon_e.blk));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic px(input logic [7:0] d, input logic sob, input int gap_pct);
    while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
      @(posedge clk); #1;
    end
    pix_valid = 1'b1; pix_data = d; pix_sob = sob;
    model_accept(d, sob);
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_sob = 1'b0;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; pix_sob = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_x", {x7, x6, x5, x4, x3, x2, x1, x0}, 64'd0);
    chk("rst_flags", 64'({pix_ready, row_valid, blk_first, blk_last, err_sob, drop}), 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    chk("rst_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    m_active = 1'b0; m_col = 0; m_row = 0; m_blk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 64'(pix_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_one_edge_later", 64'(pix_ready), 64'd1);
  endtask

  task automatic begin_test();
    got_q.delete(); got_cyc.delete();
    exp_drop = 0; exp_err = 0; drop_seen = 0; err_seen = 0;
  endtask

  task automatic end_test(input string tag);
    idle(4);
    chk({tag, "_rows_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_drops"}, 64'(drop_seen), 64'(exp_drop));
    chk({tag, "_errs"}, 64'(err_seen), 64'(exp_err));
  endtask

  task automatic send_block(input int kind, input int base, input int gap_pct);
    logic [7:0] d;
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       d = 8'(base + i);
        1:       d = 8'(base);
        default: d = 8'($urandom_range(255, 0));
      endcase
      px(d, (i == 0), gap_pct);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    begin_test();
    do_reset();

    // 1: ramp block 0..63, continuous
    begin_test();
    send_block(0, 0, 0);
    idle(3);
    chk("t1_row_count", 64'(got_q.size()), 64'd8);
    if (got_q.size() == 8) begin
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(i - 128);
      chk("t1_row0_x", got_q[0].x, v);
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(56 + i - 128);
      chk("t1_row7_x", got_q[7].x, v);
      chk("t1_row7_last", 64'(got_q[7].last), 64'd1);
      chk("t1_row7_blk", 64'(got_q[7].blk), 64'd1);
      for (int i = 1; i < 8; i++) chk("t1_spacing", 64'(got_cyc[i] - got_cyc[i-1]), 64'd8);
    end
    end_test("t1");

    // 2: constant 255, 0 and 128 blocks
    begin_test();
    send_block(1, 255, 0);
    send_block(1, 0, 0);
    send_block(1, 128, 0);
    idle(3);
    chk("t2_row_count", 64'(got_q.size()), 64'd24);
    if (got_q.size() == 24) begin
      chk("t2_255_x", got_q[0].x, {8{8'h7f}});
      chk("t2_0_x", got_q[15].x, {8{8'h80}});
      chk("t2_128_x", got_q[23].x, 64'd0);
      chk("t2_blk", 64'(got_q[23].blk), 64'd4);
    end
    end_test("t2");

    // 3: pixels before any pix_sob are dropped
    begin_test();
    for (int i = 0; i < 5; i++) px(8'(200 + i), 1'b0, 0);
    for (int i = 0; i < 64; i++) px(8'(i * 3 + 7), (i == 0), 0);
    idle(3);
    chk("t3_drop_count", 64'(drop_seen), 64'd5);
    if (got_q.size() > 0) begin
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(((i * 3 + 7) & 255) - 128);
      chk("t3_row0_x", got_q[0].x, v);
    end
    end_test("t3");

    // 4: pix_sob reasserted at row 3 col 4
    begin_test();
    for (int i = 0; i < 28; i++) px(8'(i + 30), (i == 0), 0);
    px(8'd99, 1'b1, 0);
    for (int i = 1; i < 64; i++) px(8'(i * 5), 1'b0, 0);
    idle(3);
    chk("t4_err_count", 64'(err_seen), 64'd1);
    chk("t4_row_count", 64'(got_q.size()), 64'd11);
    if (got_q.size() > 3) chk("t4_restart_idx", 64'(got_q[3].idx), 64'd0);
    end_test("t4");

    // 5: four random blocks with ~30% idle cycles
    begin_test();
    do_reset();
    for (int b = 0; b < 4; b++) send_block(2, 0, 30);
    idle(3);
    chk("t5_blk_cnt", 64'(blk_cnt), 64'd4);
    chk("t5_row_count", 64'(got_q.size()), 64'd32);
    end_test("t5");

    // 6: reset at row 5 col 2, then recovery
    begin_test();
    for (int i = 0; i < 42; i++) px(8'(i + 100), (i == 0), 0);
    do_reset();
    for (int i = 0; i < 3; i++) px(8'(i + 1), 1'b0, 0);
    idle(3);
    chk("t6_drop_count", 64'(drop_seen), 64'd3);
    send_block(0, 64, 0);
    end_test("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
